// File: rtl/multicycle_pkg.sv
// ============================================================================
// Module  : multicycle_pkg
// Brief   : State encoding, opcodes and datapath select constants for the
//           multicycle RV64 controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package multicycle_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE   = 4'd0;
    localparam state_t S_FETCH  = 4'd1;
    localparam state_t S_DECODE = 4'd2;
    localparam state_t S_ADDR   = 4'd3;
    localparam state_t S_MEM_RD = 4'd4;
    localparam state_t S_MEM_WR = 4'd5;
    localparam state_t S_EXEC_R = 4'd6;
    localparam state_t S_EXEC_I = 4'd7;
    localparam state_t S_WB_ALU = 4'd8;
    localparam state_t S_WB_MEM = 4'd9;
    localparam state_t S_BRANCH = 4'd10;
    localparam state_t S_TRAP   = 4'd11;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic SRC_A_PC      = 1'b0;
    localparam logic SRC_A_REG     = 1'b1;
    localparam logic IORD_PC       = 1'b0;
    localparam logic IORD_ALUOUT   = 1'b1;
    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;
    localparam logic WB_ALUOUT     = 1'b0;
    localparam logic WB_MDR        = 1'b1;

    // Dispatch target out of DECODE; anything unsupported lands in TRAP.
    function automatic state_t decode_next(input logic [6:0] op);
        case (op)
            OP_R:         decode_next = S_EXEC_R;
            OP_ADDI:      decode_next = S_EXEC_I;
            OP_LD, OP_SD: decode_next = S_ADDR;
            OP_BEQ:       decode_next = S_BRANCH;
            default:      decode_next = S_TRAP;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_ctrl_out_decode.sv
// ============================================================================
// Module  : ctrl_out_decode
// Brief   : Combinational state -> datapath strobe decode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ctrl_out_decode
    import multicycle_pkg::*;
(
    input  state_t     state,
    input  logic       zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       illegal
);

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = IORD_PC;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_ALU;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_REG;
        alu_op     = ALU_ADD;
        mem_to_reg = WB_ALUOUT;
        reg_write  = 1'b0;
        illegal    = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRC_B_FOUR;
                // IR and PC latch only on the cycle the fetch completes.
                ir_write  = mem_ack;
                pc_write  = mem_ack;
            end
            S_DECODE: begin
                alu_src_b = SRC_B_IMM;
            end
            S_ADDR, S_EXEC_I: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = IORD_ALUOUT;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = IORD_ALUOUT;
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_REG;
                alu_op    = ALU_FUNCT;
            end
            S_WB_ALU: begin
                reg_write = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = WB_MDR;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_REG;
                alu_op    = ALU_SUB;
                pc_src    = PC_SRC_ALUOUT;
                pc_write  = zero;
            end
            S_TRAP: begin
                illegal = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
// Module  : multicycle_ctrl
// Brief   : Multicycle sequencing FSM for the RV64 core with handshaked memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    state_t           w_next;
    logic             w_retire;
    logic [CNT_W-1:0] r_retired;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = S_FETCH;
            S_FETCH:  w_next = mem_ack ? S_DECODE : S_FETCH;
            S_DECODE: w_next = decode_next(opcode);
            S_ADDR:   w_next = (opcode == OP_SD) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: w_next = mem_ack ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR: w_next = mem_ack ? S_FETCH : S_MEM_WR;
            S_EXEC_R, S_EXEC_I:           w_next = S_WB_ALU;
            S_WB_ALU, S_WB_MEM, S_BRANCH: w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_IDLE;
        endcase
    end

    // An instruction retires on the edge that leaves its final state.
    assign w_retire = (r_state == S_WB_ALU) || (r_state == S_WB_MEM) ||
                      (r_state == S_BRANCH) || ((r_state == S_MEM_WR) && mem_ack);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign retired = r_retired;

    ctrl_out_decode u_decode (
        .state      (r_state),
        .zero       (zero),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .illegal    (illegal)
    );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
// ============================================================================
// Module  : tb_multicycle_ctrl
// Brief   : Self-checking bench for multicycle_ctrl with a per-instruction model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [6:0]  opcode = 7'd0;
    logic        zero = 1'b0;
    logic        mem_ack = 1'b0;

    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0]  alu_src_b, alu_op;
    logic        mem_to_reg, reg_write, illegal;
    logic [31:0] retired;

    logic        n_mem_req, n_mem_we, n_iord, n_ir_write, n_pc_write, n_pc_src, n_alu_src_a;
    logic [1:0]  n_alu_src_b, n_alu_op;
    logic        n_mem_to_reg, n_reg_write, n_illegal;
    logic [2:0]  n_retired;

    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned exp_ret = 0;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_to_reg(mem_to_reg),
        .reg_write(reg_write), .illegal(illegal), .retired(retired)
    );

    // Narrow counter instance sharing the same stimulus, so wrap-around is reached.
    multicycle_ctrl #(.CNT_W(3)) dut_narrow (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ack(mem_ack),
        .mem_req(n_mem_req), .mem_we(n_mem_we), .iord(n_iord), .ir_write(n_ir_write),
        .pc_write(n_pc_write), .pc_src(n_pc_src), .alu_src_a(n_alu_src_a),
        .alu_src_b(n_alu_src_b), .alu_op(n_alu_op), .mem_to_reg(n_mem_to_reg),
        .reg_write(n_reg_write), .illegal(n_illegal), .retired(n_retired)
    );

    always #5 clk = ~clk;

    // Instruction kinds: 0=R-type 1=addi 2=ld 3=sd 4=beq
    function automatic logic [6:0] opc(input int kind);
        case (kind)
            0:       opc = 7'b0110011;
            1:       opc = 7'b0010011;
            2:       opc = 7'b0000011;
            3:       opc = 7'b0100011;
            default: opc = 7'b1100011;
        endcase
    endfunction

    // Entered one step after a rising edge with the DUT in FETCH; leaves it the same way.
    task automatic run_instr(input int kind, input int fw, input int mw, input logic z);
        int   cycles = 0, req_idx = 0, wait_left = 0;
        bit   in_req = 0, done = 0, is_mem;
        int   n_ir = 0, n_rw = 0, n_we = 0, n_pcw = 0, n_req = 0, n_psrc = 0, rw_cycle = -1;
        int   exp_lat, exp_rw, exp_we, exp_pcw, exp_req;
        logic [31:0] ret0;
        ret0   = retired;
        opcode = opc(kind);
        zero   = z;
        is_mem = (kind == 2) || (kind == 3);
        while (!done && cycles < 100) begin
            if (mem_req) begin
                if (!in_req) begin
                    wait_left = (req_idx == 0) ? fw : mw;
                    req_idx++;
                    in_req = 1;
                end
                if (wait_left == 0) begin
                    mem_ack = 1'b1;
                    in_req  = 0;
                end else begin
                    mem_ack = 1'b0;
                    wait_left--;
                end
            end else begin
                mem_ack = 1'($urandom_range(0, 1));
            end
            #1;
            cycles++;
            n_ir   += int'(ir_write);
            n_rw   += int'(reg_write);
            n_we   += int'(mem_we);
            n_pcw  += int'(pc_write);
            n_req  += int'(mem_req);
            n_psrc += int'(pc_src);
            if (reg_write) rw_cycle = cycles;
            @(posedge clk);
            #1;
            if (retired != ret0) done = 1;
        end
        mem_ack = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout kind=%0d: no retirement in %0d cycles", kind, cycles);
            return;
        end
        exp_ret++;
        exp_lat = ((kind == 4) ? 3 : (kind == 2) ? 5 : 4) + fw + (is_mem ? mw : 0);
        exp_rw  = (kind <= 2) ? 1 : 0;
        exp_we  = (kind == 3) ? mw + 1 : 0;
        exp_pcw = 1 + ((kind == 4 && z) ? 1 : 0);
        exp_req = fw + 1 + (is_mem ? mw + 1 : 0);

        n_tests++;
        if (cycles !== exp_lat) begin
            n_fail++;
            $display("FAIL latency kind=%0d fw=%0d mw=%0d: got %0d want %0d", kind, fw, mw, cycles, exp_lat);
        end
        n_tests++;
        if (retired !== exp_ret) begin
            n_fail++;
            $display("FAIL retired: got %0d want %0d", retired, exp_ret);
        end
        n_tests++;
        if (n_retired !== 3'(exp_ret)) begin
            n_fail++;
            $display("FAIL retired_wrap: got %0d want %0d", n_retired, exp_ret % 8);
        end
        n_tests++;
        if (n_ir !== 1) begin
            n_fail++;
            $display("FAIL ir_write_pulses kind=%0d: got %0d want 1", kind, n_ir);
        end
        n_tests++;
        if (n_rw !== exp_rw || (exp_rw == 1 && rw_cycle !== exp_lat)) begin
            n_fail++;
            $display("FAIL reg_write kind=%0d: got count %0d at cycle %0d want count %0d at cycle %0d",
                     kind, n_rw, rw_cycle, exp_rw, exp_lat);
        end
        n_tests++;
        if (n_we !== exp_we) begin
            n_fail++;
            $display("FAIL mem_we_cycles kind=%0d: got %0d want %0d", kind, n_we, exp_we);
        end
        n_tests++;
        if (n_pcw !== exp_pcw || n_psrc !== ((kind == 4) ? 1 : 0)) begin
            n_fail++;
            $display("FAIL pc_write kind=%0d z=%0b: got pcw=%0d psrc=%0d want pcw=%0d psrc=%0d",
                     kind, z, n_pcw, n_psrc, exp_pcw, (kind == 4) ? 1 : 0);
        end
        n_tests++;
        if (n_req !== exp_req) begin
            n_fail++;
            $display("FAIL mem_req_cycles kind=%0d: got %0d want %0d", kind, n_req, exp_req);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
             alu_op, mem_to_reg, reg_write, illegal} !== 15'd0 || retired !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got req=%0b we=%0b rw=%0b ill=%0b ret=%0d want all 0",
                     mem_req, mem_we, reg_write, illegal, retired);
        end
        @(negedge clk);
        reset   = 1'b0;
        exp_ret = 0;
        #1;
        n_tests++;
        if (mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_req: got %0b want 0", mem_req);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (mem_req !== 1'b1 || iord !== 1'b0 || alu_src_b !== 2'b01 || alu_op !== 2'b00) begin
            n_fail++;
            $display("FAIL first_fetch: got req=%0b iord=%0b srcb=%0b op=%0b want 1 0 01 00",
                     mem_req, iord, alu_src_b, alu_op);
        end
    endtask

    task automatic test_abort();
        opcode  = opc(3);
        mem_ack = 1'b1;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || iord !== 1'b1) begin
            n_fail++;
            $display("FAIL mem_wr_entry: got req=%0b we=%0b iord=%0b want 1 1 1", mem_req, mem_we, iord);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || reg_write !== 1'b0 || retired !== 32'd0) begin
            n_fail++;
            $display("FAIL abort: got req=%0b we=%0b rw=%0b ret=%0d want 0 0 0 0",
                     mem_req, mem_we, reg_write, retired);
        end
        exp_ret = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (mem_req !== 1'b1 || iord !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_restart: got req=%0b iord=%0b want 1 0", mem_req, iord);
        end
    endtask

    task automatic test_trap();
        opcode  = 7'b1111111;
        mem_ack = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            mem_ack = 1'($urandom_range(0, 1));
            #1;
            n_tests++;
            if (illegal !== 1'b1 || mem_req !== 1'b0 || reg_write !== 1'b0 || retired !== exp_ret) begin
                n_fail++;
                $display("FAIL trap cycle %0d: got ill=%0b req=%0b rw=%0b ret=%0d want 1 0 0 %0d",
                         i, illegal, mem_req, reg_write, retired, exp_ret);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (illegal !== 1'b0 || retired !== 32'd0) begin
            n_fail++;
            $display("FAIL trap_reset: got ill=%0b ret=%0d want 0 0", illegal, retired);
        end
        exp_ret = 0;
        @(negedge clk);
        reset   = 1'b0;
        mem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_instr(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        run_instr(1, 0, 0, 1'b0);   // addi, ack immediate
        run_instr(2, 2, 3, 1'b0);   // ld with waits
        run_instr(4, 0, 0, 1'b1);   // beq taken
        run_instr(4, 1, 0, 1'b0);   // beq not taken
        run_instr(3, 0, 2, 1'b0);   // sd with waits
        run_instr(0, 0, 0, 1'b0);   // R-type
        test_random();
        test_abort();
        run_instr(1, 1, 0, 1'b0);
        test_trap();
        run_instr(2, 0, 0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
